// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-configurable serial bit-sequence detector.
// A pattern of 1..MAX_LEN bits plus an overlap mode is loaded via cfg_load;
// every occurrence in the qualified bit stream yields a registered one-cycle
// match pulse. Optional saturating match counter under `SEQ_DET_CNT_EN`;
// without the macro, match_cnt is tied to zero.
module seq_detect_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               configured,
  output logic               match,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_cnt
);

  typedef enum logic {S_UNCFG, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               ovl_q, ovl_d;
  logic               match_q, match_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] hist_new;
  logic [LEN_W-1:0]   fill_inc;
  logic               hit;
  logic               cfg_ok;

  // Mask selecting the low len_q history bits that take part in the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) len_mask[i] = (i < int'(len_q));
  end

  // Candidate history/fill if a bit is accepted, and the match compare on them.
  always_comb begin
    hist_new = {hist_q[MAX_LEN-2:0], in_bit};
    fill_inc = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
    hit      = (((hist_new ^ pat_q) & len_mask) == '0) && (fill_inc >= len_q);
    cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  end

  // Next state: cfg_load takes priority and swallows any bit on the same edge.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    pat_d   = pat_q;
    len_d   = len_q;
    fill_d  = fill_q;
    ovl_d   = ovl_q;
    match_d = 1'b0;
    err_d   = 1'b0;
    if (cfg_load) begin
      if (cfg_ok) begin
        state_d = S_RUN;
        pat_d   = cfg_pattern;
        len_d   = cfg_len;
        ovl_d   = cfg_overlap;
        hist_d  = '0;
        fill_d  = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (in_valid && state_q == S_RUN) begin
      hist_d  = hist_new;
      // Non-overlap restarts the fill so the next match needs len fresh bits.
      fill_d  = (hit && !ovl_q) ? '0 : fill_inc;
      match_d = hit;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_UNCFG;
      hist_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      ovl_q   <= 1'b0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      ovl_q   <= ovl_d;
      match_q <= match_d;
      err_q   <= err_d;
    end
  end

  assign configured = (state_q == S_RUN);
  assign match      = match_q;
  assign cfg_err    = err_q;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count, bumped on the same edge that sets match.
  always_comb begin
    cnt_d = cnt_q;
    if (match_d && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  // Counter register; cfg_load leaves it alone, only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed, table-driven bench for seq_detect_param (MAX_LEN=8, CNT_W=2).
// Expected counter values collapse to 0 when SEQ_DET_CNT_EN is not defined.
module tb_seq_detect_param;

`ifdef SEQ_DET_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, in_valid, in_bit, cfg_load, cfg_overlap;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       configured, match, cfg_err;
  logic [1:0] match_cnt;

  seq_detect_param #(.MAX_LEN(8), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .configured(configured), .match(match),
    .cfg_err(cfg_err), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, iv, b, ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ov;
    logic       em, ee, ec;
    logic [1:0] ecnt;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic mk(input logic rst, iv, b, ld, input logic [7:0] pat,
                    input logic [3:0] len, input logic ov,
                    input logic em, ee, ec, input logic [1:0] ecnt);
    vec_t v;
    v.rst = rst; v.iv = iv; v.b = b; v.ld = ld; v.pat = pat; v.len = len;
    v.ov = ov; v.em = em; v.ee = ee; v.ec = ec; v.ecnt = ecnt;
    vq.push_back(v);
  endtask

  task automatic rr();
    mk(1, 0, 0, 0, 8'h00, 4'd0, 0, 0, 0, 0, 2'd0);
  endtask

  task automatic ld(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                    input logic ee, ec, input logic [1:0] cnt);
    mk(0, 0, 0, 1, pat, len, ov, 0, ee, ec, cnt);
  endtask

  task automatic bt(input logic iv, b, em, ec, input logic [1:0] cnt);
    mk(0, iv, b, 0, 8'h00, 4'd0, 0, em, 0, ec, cnt);
  endtask

  // Drive one vector on the falling edge, check outputs just after the rising edge.
  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    reset = v.rst; in_valid = v.iv; in_bit = v.b; cfg_load = v.ld;
    cfg_pattern = v.pat; cfg_len = v.len; cfg_overlap = v.ov;
    @(posedge clk);
    #1;
    chk({nm, " match"},      int'(match),      int'(v.em));
    chk({nm, " cfg_err"},    int'(cfg_err),    int'(v.ee));
    chk({nm, " configured"}, int'(configured), int'(v.ec));
    chk({nm, " match_cnt"},  int'(match_cnt),  CNT_EN ? int'(v.ecnt) : 0);
  endtask

  initial begin
    vec_t v;
    logic [7:0] a5;
    int         cnt;
    reset = 1; in_valid = 0; in_bit = 0; cfg_load = 0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;

    // 101, overlap: matches after 3rd and 5th bits; bits ignored before config
    rr(); bt(1, 1, 0, 0, 0);
    ld(8'b101, 3, 1, 0, 1, 0);
    bt(1, 1, 0, 1, 0); bt(1, 0, 0, 1, 0); bt(1, 1, 1, 1, 1);
    bt(1, 0, 0, 1, 1); bt(1, 1, 1, 1, 2); bt(0, 0, 0, 1, 2);
    // 101, no overlap: 5th bit must not match, 7th does
    rr(); ld(8'b101, 3, 0, 0, 1, 0);
    bt(1, 1, 0, 1, 0); bt(1, 0, 0, 1, 0); bt(1, 1, 1, 1, 1);
    bt(1, 0, 0, 1, 1); bt(1, 1, 0, 1, 1); bt(1, 0, 0, 1, 1); bt(1, 1, 1, 1, 2);
    // 1101 with junk above len, gaps in in_valid
    rr(); ld(8'b11111101, 4, 1, 0, 1, 0);
    bt(1, 1, 0, 1, 0); bt(1, 1, 0, 1, 0); bt(1, 1, 0, 1, 0); bt(1, 0, 0, 1, 0);
    bt(0, 1, 0, 1, 0); bt(0, 0, 0, 1, 0); bt(1, 1, 1, 1, 1);
    // reload clears history
    rr(); ld(8'b101, 3, 1, 0, 1, 0);
    bt(1, 1, 0, 1, 0); bt(1, 0, 0, 1, 0);
    ld(8'b101, 3, 1, 0, 1, 0);
    bt(1, 1, 0, 1, 0); bt(1, 0, 0, 1, 0); bt(1, 1, 1, 1, 1);
    // illegal lengths, then illegal reload while running keeps old config
    rr(); ld(8'h01, 0, 0, 1, 0, 0); bt(0, 0, 0, 0, 0);
    ld(8'h01, 9, 0, 1, 0, 0); bt(1, 1, 0, 0, 0);
    ld(8'h01, 1, 0, 0, 1, 0); ld(8'h00, 0, 1, 1, 1, 0);
    bt(1, 1, 1, 1, 1); bt(1, 0, 0, 1, 1);
    // pattern 11 overlap: back-to-back matches
    rr(); ld(8'b11, 2, 1, 0, 1, 0);
    bt(1, 1, 0, 1, 0); bt(1, 1, 1, 1, 1); bt(1, 1, 1, 1, 2); bt(1, 0, 0, 1, 2);
    // len=1: ten 1s, counter saturates at 3; reset mid-stream
    rr(); ld(8'h01, 1, 0, 0, 1, 0);
    for (int k = 1; k <= 10; k++) bt(1, 1, 1, 1, (k > 3) ? 2'd3 : 2'(k));
    bt(1, 0, 0, 1, 3); bt(1, 1, 1, 1, 3);
    mk(1, 1, 1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 2'd0);
    bt(1, 1, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("row%0d", i));

    // Full-length pattern, non-overlap: matches after bit 8 and bit 16 only
    a5 = 8'hA5;
    cnt = 0;
    mk(1, 0, 0, 0, 8'h00, 4'd0, 0, 0, 0, 0, 2'd0); apply(vq[$], "len8 rst");
    mk(0, 0, 0, 1, a5, 4'd8, 0, 0, 0, 1, 2'd0);    apply(vq[$], "len8 ld");
    for (int k = 0; k < 16; k++) begin
      logic em;
      em = (k == 7) || (k == 15);
      if (em) cnt++;
      v.rst = 0; v.iv = 1; v.b = a5[7 - (k % 8)]; v.ld = 0; v.pat = '0;
      v.len = '0; v.ov = 0; v.em = em; v.ee = 0; v.ec = 1; v.ecnt = 2'(cnt);
      apply(v, $sformatf("len8 bit%0d", k));
    end

    // Bit on the cfg_load edge is discarded, next bit matches
    mk(1, 0, 0, 0, 8'h00, 4'd0, 0, 0, 0, 0, 2'd0); apply(vq[$], "disc rst");
    mk(0, 1, 1, 1, 8'h01, 4'd1, 1, 0, 0, 1, 2'd0); apply(vq[$], "disc ld");
    mk(0, 1, 1, 0, 8'h00, 4'd0, 0, 1, 0, 1, 2'd1); apply(vq[$], "disc bit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Configurable serial bit-sequence detector: the parametrised successor to the fixed-pattern detectors in our FSM library. A pattern of 1..MAX_LEN bits and an overlap mode are loaded at runtime. The block then flags every occurrence of that pattern in a qualified serial bit stream, with a registered one-cycle match pulse and an optional saturating match counter. It sits behind serial front-ends (UART RX, line decoders) as a sync-word or framing detector.

## Interface
- MAX_LEN, 8: maximum pattern length in bits; must be ≥ 2.
- LEN_W, $clog2(MAX_LEN)+1: width of the length field.
- CNT_W, 8: width of the match counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies in_bit; bit is consumed on any edge where in_valid=1.
- in_bit  in  1  serial data bit.
- cfg_load  in  1  load strobe for configuration.
- cfg_pattern  in  MAX_LEN  pattern; cfg_pattern[len-1] is the first bit received, cfg_pattern[0] the last.
- cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
- configured  out  1  high once a legal configuration has been loaded.
- match  out  1  one-cycle registered match pulse.
- cfg_err  out  1  one-cycle pulse on rejected cfg_load.
- match_cnt  out  CNT_W  saturating match count; present only with SEQ_DET_CNT_EN.

## Operation
- States:
  - UNCFG: after reset; input bits ignored; match never asserts.
  - RUN: detection active.
- UNCFG→RUN: legal cfg_load. There is no return to UNCFG except reset.
- Registers:
  - hist[MAX_LEN-1:0]: shift history.
  - fill (0..MAX_LEN, saturating): bits accepted since last clear.
  - Latched pattern, len and overlap.
- Accepted bit in RUN:
  - hist <= {hist[MAX_LEN-2:0], in_bit}.
  - fill <= min(fill+1, MAX_LEN).
- Match condition, evaluated on the new hist and fill: (new fill ≥ len) AND new hist[len-1:0] == pattern[len-1:0]. Bits above len are don't-care.
- On match:
  - match <= 1 on that edge.
  - overlap=1: fill continues.
  - overlap=0: fill <= 0, so the next match requires len fresh bits.
- cfg_load:
  - Legal (1 ≤ cfg_len ≤ MAX_LEN): latch pattern, len and overlap; clear hist and fill; configured <= 1.
  - Illegal: cfg_err <= 1; state and configuration unchanged.
  - Any in_valid on the same edge is discarded.
  - match_cnt is not cleared by cfg_load.
- in_valid=0: nothing changes; match deasserts.
- len=1: every accepted bit equal to pattern[0] matches, in both modes.

## Timing
- Reset values:
  - match=0, cfg_err=0, configured=0, match_cnt=0.
  - hist=0, fill=0, pattern=0, len=0, overlap=0.
  - State UNCFG.
- Latency:
  - match is high in the cycle after the edge that sampled the completing bit. This is registered Mealy: a single flop after the combinational compare.
  - Back-to-back matches on consecutive accepted bits produce consecutive match cycles, e.g. len=1, or pattern 11 with overlap.
- Priority on one edge: reset > cfg_load > in_valid.
- Reset mid-stream: a partial match is discarded, and the configuration is lost (back to UNCFG).
- match_cnt:
  - Increments on the same edge match is set.
  - Saturates at 2^CNT_W−1; no wrap.

## Configuration
- SEQ_DET_CNT_EN defined: match_cnt is implemented as above.
- SEQ_DET_CNT_EN undefined: no counter is synthesised, and match_cnt is driven to constant 0. The port remains in the interface so the instantiation is unchanged.
- Detection and match behaviour are identical in both builds.

## Test plan
- Reset, then load pattern=…101, len=3, overlap=1, then stream 1,0,1,0,1 with in_valid=1 -> match high one cycle after the 3rd and 5th bits; with counter build, match_cnt=2.
- Same stream with overlap=0 -> match only after the 3rd bit; match_cnt=1.
- Load len=4, pattern=1101; stream 1,1,1,0,1, then drop in_valid for 2 cycles mid-stream -> single match after the last 1; gaps do not break the match.
- Stream 1,0 then cfg_load the same 101 config, then 1 -> no match (history cleared); then 0,1 -> match.
- cfg_load with cfg_len=0, then with cfg_len=MAX_LEN+1 -> cfg_err pulses each time; configured stays 0; bits ignored.
- CNT_W=2, len=1, pattern=1, ten consecutive 1s -> ten match cycles; match_cnt saturates at 3. Assert reset mid-stream -> all outputs 0 next cycle.
